vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_delay_line.sv | 36 +++
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// VGA timing package: 640x480@60 mode constants
// and the control bundle carried down the alignment pipe.
package vga_pkg;

  localparam int STD_H_ACTIVE = 640;
  localparam int STD_H_FP     = 16;
  localparam int STD_H_SYNC   = 96;
  localparam int STD_H_BP     = 48;

  localparam int STD_V_ACTIVE = 480;
  localparam int STD_V_FP     = 10;
  localparam int STD_V_SYNC   = 2;
  localparam int STD_V_BP     = 33;

  localparam int STD_DATA_W   = 16;

  // Sync bits are active-high internally; polarity applied at the pins.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } vga_ctl_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipe with synchronous clear;
// pre_o is the value about to enter the last stage.
module vga_delay_line #(
  parameter int W = 3,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] pre_o,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) pipe_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < D; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  if (D == 1) begin : g_short
    assign pre_o = d_i;
  end else begin : g_long
    assign pre_o = pipe_q[D-2];
  end

  assign q_o = pipe_q[D-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, pixel fetch requests,
// and sync/de aligned to the pixel source read latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = STD_H_ACTIVE,
  parameter int H_FP     = STD_H_FP,
  parameter int H_SYNC   = STD_H_SYNC,
  parameter int H_BP     = STD_H_BP,
  parameter int V_ACTIVE = STD_V_ACTIVE,
  parameter int V_FP     = STD_V_FP,
  parameter int V_SYNC   = STD_V_SYNC,
  parameter int V_BP     = STD_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DATA_W   = STD_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int CNT_W    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              underflow_clr,
  output logic              pix_req,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic [DATA_W-1:0] vga_rgb,
  output logic              frame_start,
  output logic              line_start,
  output logic              underflow
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_A0    = H_SYNC + H_BP;
  localparam int H_A1    = H_A0 + H_ACTIVE;
  localparam int V_A0    = V_SYNC + V_BP;
  localparam int V_A1    = V_A0 + V_ACTIVE;

  logic [CNT_W-1:0]  h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]  v_cnt_q, v_cnt_d;
  logic [DATA_W-1:0] rgb_q, rgb_d;
  logic              uf_q, uf_d;
  logic              h_act, v_act;
  vga_ctl_t          ctl_raw, ctl_pre, ctl_dly;

  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (en) begin
      if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        if (v_cnt_q != CNT_W'(V_TOTAL - 1))
          v_cnt_d = v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
      end
    end
  end

  assign h_act = (h_cnt_q >= CNT_W'(H_A0)) &&
                 (h_cnt_q <  CNT_W'(H_A1));
  assign v_act = (v_cnt_q >= CNT_W'(V_A0)) &&
                 (v_cnt_q <  CNT_W'(V_A1));

  assign pix_req = en & h_act & v_act;
  assign pix_x   = pix_req ? h_cnt_q - CNT_W'(H_A0) : '0;
  assign pix_y   = pix_req ? v_cnt_q - CNT_W'(V_A0) : '0;

  // Gated by rst_n so no pulse escapes while reset holds the counters.
  assign line_start  = rst_n & en & (h_cnt_q == '0);
  assign frame_start = line_start & (v_cnt_q == '0);

  assign ctl_raw.de = pix_req;
  assign ctl_raw.hs = en & (h_cnt_q < CNT_W'(H_SYNC));
  assign ctl_raw.vs = en & (v_cnt_q < CNT_W'(V_SYNC));

  vga_delay_line #(
    .W ($bits(vga_ctl_t)),
    .D (RD_LAT + 1)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (~en),
    .d_i   (ctl_raw),
    .pre_o (ctl_pre),
    .q_o   (ctl_dly)
  );

  // din arrives RD_LAT cycles after the request, so it is
  // captured against the stage feeding the output register.
  always_comb begin
    rgb_d = '0;
    uf_d  = uf_q;
    if (en && ctl_pre.de && din_valid) rgb_d = din;
    if (underflow_clr) uf_d = 1'b0;
    if (en && ctl_pre.de && !din_valid) uf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      rgb_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      rgb_q   <= rgb_d;
      uf_q    <= uf_d;
    end
  end

  assign vga_de    = ctl_dly.de;
  assign vga_hs    = ctl_dly.hs ? HS_POL : ~HS_POL;
  assign vga_vs    = ctl_dly.vs ? VS_POL : ~VS_POL;
  assign vga_rgb   = rgb_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: three instances (RD_LAT 0/1/4) on a 15x8 raster,
// checked each cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int HT = 15;
  localparam int VT = 8;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        din_valid = 1'b0;
  logic        underflow_clr = 1'b0;
  logic [15:0] din [3];
  logic [2:0]  pix_req, vga_hs, vga_vs, vga_de;
  logic [2:0]  frame_start, line_start, underflow;
  logic [11:0] pix_x [3];
  logic [11:0] pix_y [3];
  logic [15:0] vga_rgb [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b1), .DATA_W(16),
      .RD_LAT(g == 0 ? 0 : (g == 1 ? 1 : 4)), .CNT_W(12)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .din           (din[g]),
      .din_valid     (din_valid),
      .underflow_clr (underflow_clr),
      .pix_req       (pix_req[g]),
      .pix_x         (pix_x[g]),
      .pix_y         (pix_y[g]),
      .vga_hs        (vga_hs[g]),
      .vga_vs        (vga_vs[g]),
      .vga_de        (vga_de[g]),
      .vga_rgb       (vga_rgb[g]),
      .frame_start   (frame_start[g]),
      .line_start    (line_start[g]),
      .underflow     (underflow[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  int de_cnt = 0;
  int t = 0;
  bit en_c = 1'b1;
  bit dv_c = 1'b1;
  bit clr_c = 1'b0;
  bit dv_prev = 1'b0;
  bit uf [3] = '{1'b0, 1'b0, 1'b0};

  function automatic int lat(int i);
    return i == 0 ? 0 : (i == 1 ? 1 : 4);
  endfunction

  // k = cycles since the raster last restarted at h=0, v=0
  function automatic bit act(int k);
    int h, v;
    if (k < 0) return 1'b0;
    h = k % HT;
    v = (k / HT) % VT;
    return h >= 5 && h < 13 && v >= 3 && v < 7;
  endfunction

  function automatic int xo(int k);
    return k % HT - 5;
  endfunction

  function automatic int yo(int k);
    return (k / HT) % VT - 3;
  endfunction

  task automatic chk(string tag, int i,
                     logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s dut%0d t=%0d obs=%0h exp=%0h",
             tag, i, t, obs, exp);
    end
  endtask

  task automatic drive();
    en = en_c;
    din_valid = dv_c;
    underflow_clr = clr_c;
    for (int i = 0; i < 3; i++) begin
      int k;
      k = t - lat(i);
      din[i] = (en_c && act(k)) ? 16'(xo(k)) : 16'($urandom);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      bit a, d;
      int k;
      a = en_c && act(t);
      k = t - lat(i) - 1;
      d = act(k);
      chk("pix_req", i, pix_req[i], a);
      chk("pix_x", i, pix_x[i], a ? xo(t) : 0);
      chk("pix_y", i, pix_y[i], a ? yo(t) : 0);
      chk("frame_start", i, frame_start[i], en_c && t % FT == 0);
      chk("line_start", i, line_start[i], en_c && t % HT == 0);
      chk("vga_de", i, vga_de[i], d);
      chk("vga_hs", i, vga_hs[i], (k >= 0 && k % HT < 3) ? 0 : 1);
      chk("vga_vs", i, vga_vs[i],
          (k >= 0 && (k / HT) % VT < 2) ? 1 : 0);
      chk("vga_rgb", i, vga_rgb[i], (d && dv_prev) ? xo(k) : 0);
      chk("underflow", i, underflow[i], uf[i]);
      if (i == 1 && vga_de[1] === 1'b1) de_cnt++;
    end
  endtask

  task automatic check_reset();
    for (int i = 0; i < 3; i++) begin
      chk("rst_pix_req", i, pix_req[i], 0);
      chk("rst_pix_x", i, pix_x[i], 0);
      chk("rst_pix_y", i, pix_y[i], 0);
      chk("rst_frame_start", i, frame_start[i], 0);
      chk("rst_line_start", i, line_start[i], 0);
      chk("rst_vga_de", i, vga_de[i], 0);
      chk("rst_vga_hs", i, vga_hs[i], 1);
      chk("rst_vga_vs", i, vga_vs[i], 0);
      chk("rst_vga_rgb", i, vga_rgb[i], 0);
      chk("rst_underflow", i, underflow[i], 0);
    end
  endtask

  task automatic advance();
    for (int i = 0; i < 3; i++) begin
      if (en_c && act(t - lat(i)) && !dv_c) uf[i] = 1'b1;
      else if (clr_c) uf[i] = 1'b0;
    end
    dv_prev = dv_c;
    t = en_c ? t + 1 : 0;
  endtask

  task automatic run(int n, int dv_zero_pct, int clr_pct);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_all();
      @(posedge clk);
      #1;
      advance();
      dv_c = $urandom_range(99) >= dv_zero_pct;
      clr_c = $urandom_range(99) < clr_pct;
      drive();
    end
  endtask

  // Release reset mid-cycle; the raster restarts at h=0, v=0.
  task automatic release_reset();
    #1;
    rst_n = 1'b1;
    t = 0;
    de_cnt = 0;
    dv_c = 1'b1;
    clr_c = 1'b0;
    drive();
    #1;
    check_all();
    @(posedge clk);
    #1;
    advance();
    drive();
  endtask

  task automatic pulse_reset();
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) uf[i] = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    check_reset();
    @(negedge clk);
    check_reset();
    release_reset();
  endtask

  initial begin
    en_c = 1'b1;
    drive();
    #3;
    check_reset();
    @(negedge clk);
    check_reset();
    release_reset();

    // Two clean frames: 4 bursts of 8 per frame on the aligned de.
    run(239, 0, 0);
    chk("de_cycles_2frames", 1, de_cnt, 64);

    run(200, 15, 10);

    // Single missing pixel with clear asserted on the same cycle.
    for (int c = 0; c < 2 * FT && !(act(t - 1) && xo(t - 1) == 3); c++)
      run(1, 0, 0);
    dv_c = 1'b0;
    clr_c = 1'b1;
    drive();
    run(4, 0, 0);
    run(2, 0, 100);

    // Drop enable mid active line, then restart.
    for (int c = 0; c < 2 * FT && !(act(t) && xo(t) == 3); c++)
      run(1, 0, 0);
    en_c = 1'b0;
    drive();
    run(5, 0, 0);
    en_c = 1'b1;
    drive();
    run(150, 10, 5);

    // Asynchronous reset mid frame.
    for (int c = 0; c < 2 * FT && t % FT != 70; c++)
      run(1, 0, 0);
    pulse_reset();
    run(150, 10, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
